// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the spi_shifter SPI mode-0 master.
package spi_pkg;

    // Transfer sequencer states: one LOW/HIGH pair per bit, then a single DONE cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } spi_state_t;

    // Bit-order encoding of lsb_first_in.
    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCLK half-period down-counter. A load restarts the count at
// load_val_i; tick_o is high in the last cycle of the half-period, so a
// half-period lasts load_val_i+1 cycles (2^DIV_WIDTH for the all-ones value).
module spi_clk_div #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] load_val_i,
    output logic                 tick_o
);

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    // Next count: reload on request, otherwise count down and park at zero.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_shifter.sv
// spi_shifter: SPI mode-0 master, one WIDTH-bit full-duplex word per request,
// runtime SCLK divider and bit order. Optional active-low chip select output
// cs_n_out is present when the macro SPI_SHIFTER_CS_EN is defined.
module spi_shifter
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 start_in,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 lsb_first_in,
    input  logic [DIV_WIDTH-1:0] div_in,
    output logic                 ready_out,
    output logic                 done_out,
    output logic [WIDTH-1:0]     data_out,
    output logic                 sclk_out,
    output logic                 mosi_out,
    input  logic                 miso_in
`ifdef SPI_SHIFTER_CS_EN
    ,
    output logic                 cs_n_out
`endif
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] BITS    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    spi_state_t           state_q, state_d;
    logic [WIDTH-1:0]     tx_q, tx_d;
    logic [WIDTH-1:0]     rx_q, rx_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 lsb_q, lsb_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 accept;
    logic                 tick;
    logic                 last_bit;
    logic                 div_load;
    logic [DIV_WIDTH-1:0] div_load_val;

    // Ready is forced low during reset even though the state is already IDLE.
    assign ready_out = (state_q == IDLE) && !reset_in;
    assign accept    = ready_out && start_in;
    // The bit counter advances on HIGH entry, so in HIGH it equals bits received.
    assign last_bit  = (cnt_q >= BITS);

    spi_clk_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clk_div (
        .clk_i      (clk_in),
        .reset_i    (reset_in),
        .load_i     (div_load),
        .load_val_i (div_load_val),
        .tick_o     (tick)
    );

    // Sequencer next state: each SCLK level ends on a divider tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = LOW;
            LOW:  if (tick)   state_d = HIGH;
            HIGH: if (tick)   state_d = last_bit ? DONE : LOW;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state: capture on accept, sample MISO entering HIGH, shift MOSI entering LOW.
    always_comb begin
        tx_d         = tx_q;
        rx_d         = rx_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        lsb_d        = lsb_q;
        div_d        = div_q;
        mosi_d       = mosi_q;
        div_load     = 1'b0;
        div_load_val = div_q;

        if (accept) begin
            tx_d         = data_in;
            rx_d         = '0;
            cnt_d        = '0;
            lsb_d        = lsb_first_in;
            div_d        = div_in;
            div_load     = 1'b1;
            div_load_val = div_in;
            mosi_d       = (lsb_first_in == LSB_FIRST) ? data_in[0] : data_in[WIDTH-1];
        end

        if (state_q == LOW && tick) begin
            div_load = 1'b1;
            cnt_d    = cnt_q + CNT_ONE;
            if (lsb_q == LSB_FIRST) begin
                rx_d = {miso_in, rx_q[WIDTH-1:1]};
            end else begin
                rx_d = {rx_q[WIDTH-2:0], miso_in};
            end
        end

        if (state_q == HIGH && tick) begin
            div_load = 1'b1;
            if (last_bit) begin
                data_d = rx_q;
            end else if (lsb_q == MSB_FIRST) begin
                tx_d   = {tx_q[WIDTH-2:0], 1'b0};
                mosi_d = tx_q[WIDTH-2];
            end else begin
                tx_d   = {1'b0, tx_q[WIDTH-1:1]};
                mosi_d = tx_q[1];
            end
        end

        // SCLK is a register that follows the next state, so it never glitches.
        sclk_d = (state_d == HIGH);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            lsb_q   <= 1'b0;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            lsb_q   <= lsb_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    assign done_out = (state_q == DONE);
    assign data_out = data_q;
    assign sclk_out = sclk_q;
    assign mosi_out = mosi_q;

`ifdef SPI_SHIFTER_CS_EN
    logic cs_n_q;

    // Chip select is low from LOW entry through the DONE cycle.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cs_n_q <= 1'b1;
        end else begin
            cs_n_q <= (state_d == IDLE);
        end
    end

    assign cs_n_out = cs_n_q;
`endif

endmodule

// File: tb/tb_spi_shifter.sv
// tb_spi_shifter: self-checking bench for spi_shifter (WIDTH=8, DIV_WIDTH=8).
// Table-driven directed transfers, randomized transfers against a bit-level
// model, and a mid-transfer reset sequence. Chip-select checks are active
// when SPI_SHIFTER_CS_EN is defined.
module tb_spi_shifter;

    localparam int W  = 8;
    localparam int DW = 8;

    logic          clk_in;
    logic          reset_in;
    logic          start_in;
    logic [W-1:0]  data_in;
    logic          lsb_first_in;
    logic [DW-1:0] div_in;
    logic          ready_out;
    logic          done_out;
    logic [W-1:0]  data_out;
    logic          sclk_out;
    logic          mosi_out;
    logic          miso_in;
`ifdef SPI_SHIFTER_CS_EN
    logic          cs_n_out;
`endif

    int checks   = 0;
    int failures = 0;

    spi_shifter #(
        .WIDTH     (W),
        .DIV_WIDTH (DW)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .start_in     (start_in),
        .data_in      (data_in),
        .lsb_first_in (lsb_first_in),
        .div_in       (div_in),
        .ready_out    (ready_out),
        .done_out     (done_out),
        .data_out     (data_out),
        .sclk_out     (sclk_out),
        .mosi_out     (mosi_out),
        .miso_in      (miso_in)
`ifdef SPI_SHIFTER_CS_EN
        ,
        .cs_n_out     (cs_n_out)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Wire order of the transmitted bits, first bit placed at the MSB position.
    function automatic logic [W-1:0] model_mosi(input logic [W-1:0] d, input logic lsb);
        logic [W-1:0] s;
        for (int i = 0; i < W; i++) s[W-1-i] = lsb ? d[i] : d[W-1-i];
        return s;
    endfunction

    // Received word from a wire-order stream (first bit at MSB position).
    function automatic logic [W-1:0] model_rx(input logic [W-1:0] s, input logic lsb);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (lsb) r[i] = s[W-1-i];
            else     r[W-1-i] = s[W-1-i];
        end
        return r;
    endfunction

    // One transfer, entered and left on a falling edge with the DUT idle.
    task automatic run_xfer(input string tag, input logic [W-1:0] data, input logic lsb,
                            input logic [DW-1:0] div, input logic loop, input logic [W-1:0] stream,
                            input logic garble, input logic [W-1:0] exp_mosi,
                            input logic [W-1:0] exp_data, input int exp_cycles);
        int           cycles   = 0;
        int           rises    = 0;
        int           run_len  = 0;
        int           limit    = exp_cycles + 50;
        logic         prev     = 1'b0;
        logic         seen     = 1'b0;
        logic         sclk_bad = 1'b0;
        logic         busy_bad = 1'b0;
        logic         cs_bad   = 1'b0;
        logic [W-1:0] mosi_rec = '0;
        logic [W-1:0] hold     = data_out;

        start_in     = 1'b1;
        data_in      = data;
        lsb_first_in = lsb;
        div_in       = div;
        miso_in      = 1'b0;
        while (!seen && cycles < limit) begin
            @(negedge clk_in);
            cycles++;
            if (garble) begin
                start_in     = 1'b1;
                data_in      = W'($urandom);
                div_in       = DW'($urandom);
                lsb_first_in = 1'($urandom);
            end else begin
                start_in = 1'b0;
            end
            if (sclk_out === prev) begin
                run_len++;
            end else begin
                if (run_len != int'(div) + 1) sclk_bad = 1'b1;
                if (sclk_out === 1'b1) begin
                    if (rises < W) mosi_rec[W-1-rises] = mosi_out;
                    rises++;
                end
                run_len = 1;
                prev    = sclk_out;
            end
            if (done_out === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (ready_out !== 1'b0) busy_bad = 1'b1;
                if (data_out !== hold) busy_bad = 1'b1;
                if (sclk_out === 1'b0 && rises < W) miso_in = loop ? mosi_out : stream[W-1-rises];
            end
`ifdef SPI_SHIFTER_CS_EN
            if (cs_n_out !== 1'b0) cs_bad = 1'b1;
`endif
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " done_cycle"}, cycles, exp_cycles);
        check({tag, " data_out"}, 32'(data_out), 32'(exp_data));
        check({tag, " mosi_bits"}, 32'(mosi_rec), 32'(exp_mosi));
        check({tag, " sclk_rises"}, rises, W);
        check({tag, " sclk_levels_bad"}, 32'(sclk_bad), 32'd0);
        check({tag, " busy_outputs_bad"}, 32'(busy_bad), 32'd0);
`ifdef SPI_SHIFTER_CS_EN
        check({tag, " cs_low_bad"}, 32'(cs_bad), 32'd0);
`endif
        @(negedge clk_in);
        start_in = 1'b0;
        check({tag, " ready_after"}, 32'(ready_out), 32'd1);
        check({tag, " done_pulse_end"}, 32'(done_out), 32'd0);
        check({tag, " data_hold"}, 32'(data_out), 32'(exp_data));
`ifdef SPI_SHIFTER_CS_EN
        check({tag, " cs_high_after"}, 32'(cs_n_out), 32'd1);
`endif
    endtask

    typedef struct {
        logic [W-1:0]  data;
        logic          lsb;
        logic [DW-1:0] div;
        logic          loop;
        logic [W-1:0]  stream;
        logic          garble;
        logic [W-1:0]  exp_mosi;
        logic [W-1:0]  exp_data;
        int            exp_cycles;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 8'd0,   1'b1, 8'h00, 1'b0, 8'hA5, 8'hA5, 17};
        vecs[1] = '{8'h01, 1'b1, 8'd0,   1'b1, 8'h00, 1'b0, 8'h80, 8'h01, 17};
        vecs[2] = '{8'h3C, 1'b0, 8'd3,   1'b1, 8'h00, 1'b1, 8'h3C, 8'h3C, 65};
        vecs[3] = '{8'h5A, 1'b0, 8'd0,   1'b0, 8'h96, 1'b1, 8'h5A, 8'h96, 17};
        vecs[4] = '{8'hC3, 1'b1, 8'd1,   1'b0, 8'h96, 1'b1, 8'hC3, 8'h69, 33};
        vecs[5] = '{8'h81, 1'b0, 8'd255, 1'b1, 8'h00, 1'b0, 8'h81, 8'h81, 4097};

        reset_in     = 1'b1;
        start_in     = 1'b1;
        data_in      = 8'hFF;
        lsb_first_in = 1'b0;
        div_in       = '0;
        miso_in      = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset ready", 32'(ready_out), 32'd0);
        check("reset sclk", 32'(sclk_out), 32'd0);
        check("reset mosi", 32'(mosi_out), 32'd0);
        check("reset done", 32'(done_out), 32'd0);
        check("reset data_out", 32'(data_out), 32'd0);
`ifdef SPI_SHIFTER_CS_EN
        check("reset cs_n", 32'(cs_n_out), 32'd1);
`endif
        start_in = 1'b0;
        reset_in = 1'b0;
        @(negedge clk_in);
        check("post-reset ready", 32'(ready_out), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].data, vecs[i].lsb, vecs[i].div, vecs[i].loop,
                     vecs[i].stream, vecs[i].garble, vecs[i].exp_mosi, vecs[i].exp_data,
                     vecs[i].exp_cycles);
        end

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0]  d      = W'($urandom);
            logic          lsb    = 1'($urandom_range(0, 1));
            logic [DW-1:0] div    = DW'($urandom_range(0, 4));
            logic          loop   = 1'($urandom_range(0, 1));
            logic [W-1:0]  stream = W'($urandom);
            logic          garble = 1'($urandom_range(0, 1));
            logic [W-1:0]  em     = model_mosi(d, lsb);
            logic [W-1:0]  ed     = model_rx(loop ? em : stream, lsb);
            run_xfer($sformatf("rnd%0d", i), d, lsb, div, loop, stream, garble, em, ed,
                     2 * W * (int'(div) + 1) + 1);
        end

        // Load a non-zero word so the abort must visibly clear data_out.
        run_xfer("pre-abort", 8'hA5, 1'b0, 8'd0, 1'b1, 8'h00, 1'b0, 8'hA5, 8'hA5, 17);

        begin
            int   rises = 0;
            int   n     = 0;
            logic prev  = 1'b0;
            logic late  = 1'b0;
            start_in     = 1'b1;
            data_in      = 8'hFF;
            lsb_first_in = 1'b0;
            div_in       = 8'd0;
            while (rises < 4 && n < 100) begin
                @(negedge clk_in);
                n++;
                start_in = 1'b0;
                miso_in  = 1'b1;
                if (sclk_out === 1'b1 && prev === 1'b0) rises++;
                prev = sclk_out;
            end
            check("abort reached bit 4", rises, 4);
            reset_in = 1'b1;
            #1;
            check("abort ready during reset", 32'(ready_out), 32'd0);
            @(negedge clk_in);
            check("abort sclk", 32'(sclk_out), 32'd0);
            check("abort mosi", 32'(mosi_out), 32'd0);
            check("abort done", 32'(done_out), 32'd0);
            check("abort data_out", 32'(data_out), 32'd0);
            check("abort ready held low", 32'(ready_out), 32'd0);
            reset_in = 1'b0;
            @(negedge clk_in);
            check("abort ready after", 32'(ready_out), 32'd1);
            for (int k = 0; k < 40; k++) begin
                @(negedge clk_in);
                if (done_out !== 1'b0 || ready_out !== 1'b1 || sclk_out !== 1'b0) late = 1'b1;
            end
            check("abort stays idle", 32'(late), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
